// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: controller states,
// address-region nibbles, owner encoding and a region decode helper.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] REGION_UART  = 4'h1;
    localparam logic [3:0] REGION_FLASH = 4'h2;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    // Region selector lives in the top nibble of the byte address.
    function automatic logic [3:0] region_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W-4];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the caller keeps the
// registered last_gnt (1 = M1 was granted last).
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // On a tie the master that did not win last time is granted.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Shares the SoC peripheral bus between the core data port (M0) and a
// secondary master (M1). One transaction in flight, steered to UART or
// SPI flash by the top address nibble, each access bounded by a timeout.
module periph_bus_arbiter
    import bus_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 64,
    parameter logic [3:0] UART_NIB    = REGION_UART,
    parameter logic [3:0] FLASH_NIB   = REGION_FLASH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_valid,
    output logic              s_uart_sel,
    output logic              s_flash_sel,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_uart_rdata,
    input  logic [DATA_W-1:0] s_flash_rdata,
    input  logic              s_uart_ready,
    input  logic              s_flash_ready
);

    // Smallest counter that can hold TIMEOUT_CYC-1 (TIMEOUT_CYC is 2..256).
    localparam int             CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    owner_t            owner;
    logic              last_gnt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              sel_uart_q;
    logic              sel_flash_q;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic [1:0]        req_vec;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_we;
    logic [3:0]        win_nib;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              in_resp;

    assign req_vec = {m1_req, m0_req};

    rr_arbiter2 u_arb (
        .req      (req_vec),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    // Route the winning master's request fields and decode its region.
    always_comb begin
        win_addr  = gnt[1] ? m1_addr  : m0_addr;
        win_wdata = gnt[1] ? m1_wdata : m0_wdata;
        win_we    = gnt[1] ? m1_we    : m0_we;
        win_nib   = region_of(win_addr);
    end

    // Only the selected slave's ready and read data are looked at.
    always_comb begin
        sel_ready = sel_uart_q ? s_uart_ready : (sel_flash_q & s_flash_ready);
        sel_rdata = sel_uart_q ? s_uart_rdata : s_flash_rdata;
    end

    // Transaction controller: grant in IDLE, wait for ready or timeout in
    // ACCESS, present the one-cycle response in RESP.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            owner       <= OWN_M0;
            last_gnt    <= 1'b1;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sel_uart_q  <= 1'b0;
            sel_flash_q <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner    <= gnt[1] ? OWN_M1 : OWN_M0;
                        last_gnt <= gnt[1];
                        addr_q   <= win_addr;
                        wdata_q  <= win_wdata;
                        we_q     <= win_we;
                        cnt      <= '0;
                        if (win_nib == UART_NIB) begin
                            sel_uart_q  <= 1'b1;
                            sel_flash_q <= 1'b0;
                            state       <= ST_ACCESS;
                        end else if (win_nib == FLASH_NIB) begin
                            sel_uart_q  <= 1'b0;
                            sel_flash_q <= 1'b1;
                            state       <= ST_ACCESS;
                        end else begin
                            // Unmapped: answer with an error, slave untouched.
                            sel_uart_q  <= 1'b0;
                            sel_flash_q <= 1'b0;
                            rsp_data    <= '0;
                            rsp_err     <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ready takes priority over a coinciding timeout.
                    if (sel_ready) begin
                        rsp_data <= we_q ? '0 : sel_rdata;
                        rsp_err  <= 1'b0;
                        state    <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        in_resp     = (state == ST_RESP);
        s_valid     = (state == ST_ACCESS);
        s_uart_sel  = s_valid & sel_uart_q;
        s_flash_sel = s_valid & sel_flash_q;
        s_we        = s_valid & we_q;
        s_addr      = addr_q;
        s_wdata     = wdata_q;
        m0_ack      = in_resp & (owner == OWN_M0);
        m1_ack      = in_resp & (owner == OWN_M1);
        m0_err      = m0_ack & rsp_err;
        m1_err      = m1_ack & rsp_err;
        m0_rdata    = m0_ack ? rsp_data : '0;
        m1_rdata    = m1_ack ? rsp_data : '0;
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
module tb_periph_bus_arbiter;

    localparam int T = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_valid, s_uart_sel, s_flash_sel, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_uart_rdata, s_flash_rdata;
    logic        s_uart_ready, s_flash_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who was granted last, and each master's
    // outstanding request (held until its ack).
    bit          exp_last;
    bit          pend_req [2];
    bit          pend_we  [2];
    logic [31:0] pend_addr[2];
    logic [31:0] pend_wd  [2];

    periph_bus_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_rdata      (m0_rdata),
        .m0_ack        (m0_ack),
        .m0_err        (m0_err),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_rdata      (m1_rdata),
        .m1_ack        (m1_ack),
        .m1_err        (m1_err),
        .s_valid       (s_valid),
        .s_uart_sel    (s_uart_sel),
        .s_flash_sel   (s_flash_sel),
        .s_we          (s_we),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_uart_rdata  (s_uart_rdata),
        .s_flash_rdata (s_flash_rdata),
        .s_uart_ready  (s_uart_ready),
        .s_flash_ready (s_flash_ready)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m0ack"}, 32'(m0_ack), 32'd0);
        chk({tag, "_m1ack"}, 32'(m1_ack), 32'd0);
        chk({tag, "_m0err"}, 32'(m0_err), 32'd0);
        chk({tag, "_m1err"}, 32'(m1_err), 32'd0);
        chk({tag, "_m0rd"}, m0_rdata, 32'd0);
        chk({tag, "_m1rd"}, m1_rdata, 32'd0);
        chk({tag, "_sval"}, 32'(s_valid), 32'd0);
        chk({tag, "_usel"}, 32'(s_uart_sel), 32'd0);
        chk({tag, "_fsel"}, 32'(s_flash_sel), 32'd0);
        chk({tag, "_swe"}, 32'(s_we), 32'd0);
        chk({tag, "_saddr"}, s_addr, 32'd0);
        chk({tag, "_swd"}, s_wdata, 32'd0);
    endtask

    task automatic drive_masters();
        m0_req   = pend_req[0];
        m0_we    = pend_we[0];
        m0_addr  = pend_addr[0];
        m0_wdata = pend_wd[0];
        m1_req   = pend_req[1];
        m1_we    = pend_we[1];
        m1_addr  = pend_addr[1];
        m1_wdata = pend_wd[1];
    endtask

    task automatic post(input int m, input logic [31:0] a, input bit we, input logic [31:0] wd);
        pend_req[m]  = 1'b1;
        pend_addr[m] = a;
        pend_we[m]   = we;
        pend_wd[m]   = wd;
    endtask

    // One transaction, entered at the falling edge of its cycle 0.
    // k: cycle in which the target slave raises ready (0 = never).
    // noise: toggle the other slave's ready and drop req early.
    task automatic txn(input int k, input bit noise, input logic [31:0] rd);
        int          win, ack_c;
        bit          mapped, is_uart, e_err, sv, ea, rdy, oth;
        logic [31:0] e_rd, a, ob_rd;
        logic        ob_ack, ob_err;
        if (!pend_req[0] && !pend_req[1]) return;
        if (pend_req[0] && pend_req[1]) win = exp_last ? 0 : 1;
        else                            win = pend_req[0] ? 0 : 1;
        exp_last = (win == 1);
        a       = pend_addr[win];
        is_uart = (a[31:28] == 4'h1);
        mapped  = is_uart || (a[31:28] == 4'h2);
        if (!mapped) begin
            ack_c = 1; e_err = 1'b1; e_rd = 32'd0;
        end else if (k >= 1 && k <= T) begin
            ack_c = k + 1; e_err = 1'b0; e_rd = pend_we[win] ? 32'd0 : rd;
        end else begin
            ack_c = T + 1; e_err = 1'b1; e_rd = 32'd0;
        end
        drive_masters();
        for (int c = 0; c <= ack_c; c++) begin
            if (c > 0) @(negedge clk_in);
            for (int m = 0; m < 2; m++) begin
                ea     = (m == win) && (c == ack_c);
                ob_ack = (m == 0) ? m0_ack : m1_ack;
                ob_err = (m == 0) ? m0_err : m1_err;
                ob_rd  = (m == 0) ? m0_rdata : m1_rdata;
                chk($sformatf("m%0d_ack_c%0d", m, c), 32'(ob_ack), 32'(ea));
                chk($sformatf("m%0d_err_c%0d", m, c), 32'(ob_err), 32'(ea && e_err));
                chk($sformatf("m%0d_rdata_c%0d", m, c), ob_rd, ea ? e_rd : 32'd0);
            end
            sv = mapped && (c >= 1) && (c < ack_c);
            chk($sformatf("s_valid_c%0d", c), 32'(s_valid), 32'(sv));
            chk($sformatf("s_uart_sel_c%0d", c), 32'(s_uart_sel), 32'(sv && is_uart));
            chk($sformatf("s_flash_sel_c%0d", c), 32'(s_flash_sel), 32'(sv && !is_uart));
            if (sv) begin
                chk($sformatf("s_addr_c%0d", c), s_addr, a);
                chk($sformatf("s_we_c%0d", c), 32'(s_we), 32'(pend_we[win]));
                chk($sformatf("s_wdata_c%0d", c), s_wdata, pend_wd[win]);
            end
            rdy = mapped && (c >= 1) && (c == k);
            oth = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!mapped) begin
                s_uart_ready  = oth;
                s_flash_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                s_uart_rdata  = $urandom;
                s_flash_rdata = $urandom;
            end else if (is_uart) begin
                s_uart_ready  = rdy;
                s_flash_ready = oth;
                s_uart_rdata  = rd;
                s_flash_rdata = $urandom;
            end else begin
                s_flash_ready = rdy;
                s_uart_ready  = oth;
                s_flash_rdata = rd;
                s_uart_rdata  = $urandom;
            end
            if (noise && c == 1) begin
                pend_req[win] = 1'b0;
                drive_masters();
            end
        end
        @(negedge clk_in);
        pend_req[win] = 1'b0;
        drive_masters();
        s_uart_ready  = 1'b0;
        s_flash_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [3:0] nibs [7] = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h2, 4'h1, 4'hF};
        return {nibs[$urandom_range(0, 6)], 28'($urandom)};
    endfunction

    initial begin
        rst_in = 1'b1;
        exp_last = 1'b1;
        for (int m = 0; m < 2; m++) begin
            pend_req[m] = 1'b0; pend_we[m] = 1'b0;
            pend_addr[m] = 32'd0; pend_wd[m] = 32'd0;
        end
        drive_masters();
        s_uart_ready = 1'b0; s_flash_ready = 1'b0;
        s_uart_rdata = 32'd0; s_flash_rdata = 32'd0;

        @(negedge clk_in);
        chk_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk_zero("post_reset");

        // Single UART read, ready in the third ACCESS cycle.
        post(0, 32'h1000_0004, 1'b0, 32'h0);
        txn(3, 1'b0, 32'h0000_00A5);

        // Contention: M0 flash write vs M1 UART read, then a second tie.
        post(0, 32'h2000_0000, 1'b1, 32'hDEAD_BEEF);
        post(1, 32'h1000_0000, 1'b0, 32'h0);
        txn(1, 1'b0, 32'h1111_2222);
        txn(1, 1'b0, 32'h3333_4444);
        post(0, 32'h1000_0010, 1'b0, 32'h0);
        post(1, 32'h2000_0020, 1'b0, 32'h0);
        txn(1, 1'b0, 32'h5555_6666);
        txn(2, 1'b0, 32'h7777_8888);

        // Unmapped address.
        post(1, 32'h3000_0000, 1'b0, 32'h0);
        txn(1, 1'b0, 32'h9999_AAAA);

        // Timeout, then ready coinciding with the last allowed cycle.
        post(0, 32'h2000_0010, 1'b0, 32'h0);
        txn(0, 1'b0, 32'hBBBB_CCCC);
        post(0, 32'h2000_0014, 1'b0, 32'h0);
        txn(T, 1'b0, 32'hCAFE_F00D);

        // Reset asserted in cycle 2 of an access.
        post(0, 32'h1000_0008, 1'b0, 32'h0);
        drive_masters();
        @(negedge clk_in);
        @(negedge clk_in);
        chk("rst_mid_sval_before", 32'(s_valid), 32'd1);
        rst_in = 1'b1;
        #1;
        chk_zero("rst_mid");
        pend_req[0] = 1'b0;
        drive_masters();
        exp_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            chk_zero($sformatf("rst_hold%0d", i));
        end
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk_zero($sformatf("rst_after%0d", i));
        end
        post(0, 32'h2000_0030, 1'b0, 32'h0);
        post(1, 32'h1000_0030, 1'b1, 32'h0BAD_CAFE);
        txn(2, 1'b0, 32'h1234_5678);
        txn(1, 1'b0, 32'h8765_4321);

        // Flash ready toggling during a UART access.
        post(0, 32'h1000_000C, 1'b0, 32'h0);
        txn(3, 1'b1, 32'h0F0F_0F0F);

        // Random traffic.
        for (int it = 0; it < 30; it++) begin
            int r;
            r = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                if (r[m] && !pend_req[m])
                    post(m, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            end
            txn($urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom);
        end
        txn(1, 1'b0, $urandom);
        txn(1, 1'b0, $urandom);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
